// File: rtl/anc_pkg.sv
// Shared types, select codes and default geometry for the ANC tap sequencer.
package anc_pkg;

    localparam int unsigned NTAPS_DEF   = 63;
    localparam int unsigned WZ_BASE_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_TAP,
        S_SWR,
        S_DONE
    } state_t;

    // RAM write-data select
    localparam logic [1:0] DIN_SHIFT  = 2'b00;
    localparam logic [1:0] DIN_WZ     = 2'b01;
    localparam logic [1:0] DIN_SAMPLE = 2'b10;

    // RAM access phase within one tap
    localparam logic [1:0] PH_SRD = 2'b00;
    localparam logic [1:0] PH_WRD = 2'b01;
    localparam logic [1:0] PH_SWR = 2'b10;
    localparam logic [1:0] PH_WWR = 2'b11;

endpackage

// File: rtl/anc_tap_counter.sv
// Tap index / phase down-counter; exposes the next values so the owner can register outputs decoded from them.
module anc_tap_counter #(
    parameter int unsigned NTAPS  = 63,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    output logic              last_tap_c,
    output logic              last_phase_c,
    output logic [ADDR_W-1:0] k_c,
    output logic [1:0]        p_c
);

    localparam logic [ADDR_W-1:0] K_TOP = ADDR_W'(NTAPS - 1);

    logic [ADDR_W-1:0] k;
    logic [1:0]        p;

    // Phase advances 0..3, then wraps and the tap index drops by one
    always_comb begin
        k_c = k;
        p_c = p;
        if (load) begin
            k_c = K_TOP;
            p_c = 2'd0;
        end else if (step) begin
            if (p == 2'd3) begin
                p_c = 2'd0;
                k_c = k - ADDR_W'(1);
            end else begin
                p_c = p + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k <= K_TOP;
            p <= 2'd0;
        end else begin
            k <= k_c;
            p <= p_c;
        end
    end

    assign last_tap_c   = (k == '0);
    assign last_phase_c = (p == 2'd3);

endmodule

// File: rtl/anc_tap_sequencer.sv
// One LMS iteration per accepted noise sample over the shared single-port RAM.
// Optional feature: ANC_SEQ_PENDING_EN keeps one busy-time sample for the next iteration.
module anc_tap_sequencer
    import anc_pkg::*;
#(
    parameter int unsigned NTAPS   = NTAPS_DEF,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned WZ_BASE = WZ_BASE_DEF,
    parameter int unsigned DATA_W  = 11
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    input  logic              SampleValid,
    input  logic [DATA_W-1:0] SampleData,
    output logic [DATA_W-1:0] SampleReg,
    output logic              Busy,
    output logic              RamEn,
    output logic              RamWe,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [1:0]        DinSel,
    output logic [1:0]        PhaseCode,
    output logic              SigBypass,
    output logic              AccClear,
    output logic              AccEn,
    output logic              ErrLatch,
    output logic              OutValid,
    output logic              Overrun
);

    localparam logic [ADDR_W-1:0] K_TOP = ADDR_W'(NTAPS - 1);
    localparam logic [ADDR_W-1:0] WZ    = ADDR_W'(WZ_BASE);

    state_t            state, state_n;
    logic              load, step, last_tap_c, last_phase_c;
    logic [ADDR_W-1:0] k_c;
    logic [1:0]        p_c;
    logic              busy_arrival;
    logic [DATA_W-1:0] sample_n;
    logic              overrun_n;
    logic              en_n, we_n, byp_n, clr_n, acc_n, err_n, ov_n;
    logic [ADDR_W-1:0] addr_n;
    logic [1:0]        din_n, ph_n;

`ifdef ANC_SEQ_PENDING_EN
    logic              pend_valid, pend_valid_n;
    logic [DATA_W-1:0] pend_data, pend_data_n;
`endif

    anc_tap_counter #(
        .NTAPS (NTAPS),
        .ADDR_W(ADDR_W)
    ) u_cnt (
        .clk         (Clk_100M),
        .reset       (Reset),
        .load        (load),
        .step        (step),
        .last_tap_c  (last_tap_c),
        .last_phase_c(last_phase_c),
        .k_c         (k_c),
        .p_c         (p_c)
    );

    assign busy_arrival = SampleValid && (state == S_ERR || state == S_TAP || state == S_SWR);

    // Next state, sample capture and overrun detection
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        step      = 1'b0;
        sample_n  = SampleReg;
        overrun_n = 1'b0;
`ifdef ANC_SEQ_PENDING_EN
        pend_valid_n = pend_valid;
        pend_data_n  = pend_data;
`endif
        case (state)
            S_IDLE: begin
                if (SampleValid) begin
                    state_n  = S_ERR;
                    sample_n = SampleData;
                end
            end
            S_ERR: begin
                state_n = S_TAP;
                load    = 1'b1;
            end
            S_TAP: begin
                if (last_tap_c && last_phase_c) state_n = S_SWR;
                else                            step    = 1'b1;
            end
            S_SWR: state_n = S_DONE;
            S_DONE: begin
                state_n = S_IDLE;
                if (SampleValid) begin
                    state_n  = S_ERR;
                    sample_n = SampleData;
`ifdef ANC_SEQ_PENDING_EN
                    overrun_n    = pend_valid;
                    pend_valid_n = 1'b0;
                end else if (pend_valid) begin
                    state_n      = S_ERR;
                    sample_n     = pend_data;
                    pend_valid_n = 1'b0;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (busy_arrival) begin
`ifdef ANC_SEQ_PENDING_EN
            overrun_n    = pend_valid;
            pend_valid_n = 1'b1;
            pend_data_n  = SampleData;
`else
            overrun_n = 1'b1;
`endif
        end
    end

    // Output decode from the next state and next tap/phase
    always_comb begin
        en_n   = 1'b0;
        we_n   = 1'b0;
        addr_n = '0;
        din_n  = DIN_SHIFT;
        ph_n   = PH_SRD;
        byp_n  = 1'b0;
        clr_n  = 1'b0;
        acc_n  = 1'b0;
        err_n  = 1'b0;
        ov_n   = 1'b0;
        case (state_n)
            S_ERR: begin
                err_n = 1'b1;
                clr_n = 1'b1;
            end
            S_TAP: begin
                en_n  = 1'b1;
                ph_n  = p_c;
                byp_n = (k_c == '0);
                case (p_c)
                    PH_SRD: addr_n = k_c;
                    PH_WRD: addr_n = WZ + k_c;
                    PH_SWR: begin
                        addr_n = k_c + ADDR_W'(1);
                        // the oldest sample falls off the end of the delay line
                        we_n   = (k_c != K_TOP);
                    end
                    PH_WWR: begin
                        addr_n = WZ + k_c;
                        we_n   = 1'b1;
                        din_n  = DIN_WZ;
                        acc_n  = 1'b1;
                    end
                    default: addr_n = '0;
                endcase
            end
            S_SWR: begin
                en_n  = 1'b1;
                we_n  = 1'b1;
                din_n = DIN_SAMPLE;
            end
            S_DONE: ov_n = 1'b1;
            default: en_n = 1'b0;
        endcase
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state     <= S_IDLE;
            SampleReg <= '0;
            Busy      <= 1'b0;
            RamEn     <= 1'b0;
            RamWe     <= 1'b0;
            RamAddr   <= '0;
            DinSel    <= DIN_SHIFT;
            PhaseCode <= PH_SRD;
            SigBypass <= 1'b0;
            AccClear  <= 1'b0;
            AccEn     <= 1'b0;
            ErrLatch  <= 1'b0;
            OutValid  <= 1'b0;
            Overrun   <= 1'b0;
`ifdef ANC_SEQ_PENDING_EN
            pend_valid <= 1'b0;
            pend_data  <= '0;
`endif
        end else begin
            state     <= state_n;
            SampleReg <= sample_n;
            Busy      <= (state_n != S_IDLE);
            RamEn     <= en_n;
            RamWe     <= we_n;
            RamAddr   <= addr_n;
            DinSel    <= din_n;
            PhaseCode <= ph_n;
            SigBypass <= byp_n;
            AccClear  <= clr_n;
            AccEn     <= acc_n;
            ErrLatch  <= err_n;
            OutValid  <= ov_n;
            Overrun   <= overrun_n;
`ifdef ANC_SEQ_PENDING_EN
            pend_valid <= pend_valid_n;
            pend_data  <= pend_data_n;
`endif
        end
    end

endmodule

// File: tb/tb_anc_tap_sequencer.sv
// Self-checking bench for anc_tap_sequencer against a cycle-offset reference model.
module tb_anc_tap_sequencer;

    localparam int NTAPS   = 63;
    localparam int ADDR_W  = 8;
    localparam int WZ_BASE = 64;
    localparam int DATA_W  = 11;
    localparam int SWR_OFF = 2 + 4 * NTAPS;
    localparam int LAST    = SWR_OFF + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, sv;
    logic [DATA_W-1:0] sd;
    logic [DATA_W-1:0] SampleReg;
    logic              Busy, RamEn, RamWe, SigBypass, AccClear, AccEn, ErrLatch, OutValid, Overrun;
    logic [ADDR_W-1:0] RamAddr;
    logic [1:0]        DinSel, PhaseCode;

    int total = 0;
    int bad   = 0;

    anc_tap_sequencer dut (
        .Clk_100M   (clk),
        .Reset      (rst),
        .SampleValid(sv),
        .SampleData (sd),
        .SampleReg  (SampleReg),
        .Busy       (Busy),
        .RamEn      (RamEn),
        .RamWe      (RamWe),
        .RamAddr    (RamAddr),
        .DinSel     (DinSel),
        .PhaseCode  (PhaseCode),
        .SigBypass  (SigBypass),
        .AccClear   (AccClear),
        .AccEn      (AccEn),
        .ErrLatch   (ErrLatch),
        .OutValid   (OutValid),
        .Overrun    (Overrun)
    );

    function automatic logic [20:0] obs();
        return {Busy, RamEn, RamWe, RamAddr, DinSel, PhaseCode,
                SigBypass, AccClear, AccEn, ErrLatch, OutValid, Overrun};
    endfunction

    // Expected outputs 'off' cycles after a sample is accepted (off 0 or > LAST: idle)
    function automatic logic [20:0] exp_vec(input int off);
        logic busy, en, we, sb, clr, acc, el, ovl;
        logic [ADDR_W-1:0] a;
        logic [1:0] ds, ph;
        int j, p, k;
        busy = (off >= 1 && off <= LAST);
        en = 0; we = 0; sb = 0; clr = 0; acc = 0; el = 0; ovl = 0;
        a = '0; ds = 2'b00; ph = 2'b00;
        j = (off - 2) / 4;
        p = (off - 2) % 4;
        k = NTAPS - 1 - j;
        if (off == 1) begin
            el = 1; clr = 1;
        end else if (off >= 2 && off < SWR_OFF) begin
            en = 1; ph = 2'(p); sb = (k == 0);
            case (p)
                0: a = ADDR_W'(k);
                1: a = ADDR_W'(WZ_BASE + k);
                2: begin a = ADDR_W'(k + 1); we = (k != NTAPS - 1); end
                default: begin a = ADDR_W'(WZ_BASE + k); we = 1; ds = 2'b01; acc = 1; end
            endcase
        end else if (off == SWR_OFF) begin
            en = 1; we = 1; ds = 2'b10;
        end else if (off == LAST) begin
            ovl = 1;
        end
        return {busy, en, we, a, ds, ph, sb, clr, acc, el, ovl, 1'b0};
    endfunction

    task automatic do_reset();
        rst = 1'b1; sv = 1'b0; sd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== 21'h0) begin
            bad++; $display("FAIL reset_outputs got=%h req=%h", obs(), 21'h0);
        end
        total++;
        if (SampleReg !== '0) begin
            bad++; $display("FAIL reset_samplereg got=%h req=0", SampleReg);
        end
    endtask

    task automatic test_single();
        logic [ADDR_W+1:0] log_q[$];
        logic [ADDR_W+1:0] exp_q[$];
        logic [ADDR_W-1:0] ea;
        int byp = 0;
        do_reset();
        sv = 1'b1; sd = 11'h155;
        for (int off = 1; off <= LAST + 1; off++) begin
            @(negedge clk); sv = 1'b0;
            total++;
            if (obs() !== exp_vec(off) || SampleReg !== 11'h155) begin
                bad++; $display("FAIL single off=%0d got=%h req=%h smp=%h", off, obs(), exp_vec(off), SampleReg);
            end
            if (RamWe === 1'b1) log_q.push_back({RamAddr, DinSel});
            if (SigBypass === 1'b1) byp++;
        end
        for (int k = NTAPS - 1; k >= 0; k--) begin
            if (k != NTAPS - 1) begin ea = ADDR_W'(k + 1); exp_q.push_back({ea, 2'b00}); end
            ea = ADDR_W'(WZ_BASE + k); exp_q.push_back({ea, 2'b01});
        end
        ea = '0; exp_q.push_back({ea, 2'b10});
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++; $display("FAIL write_count got=%0d req=%0d", log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (log_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL write_log idx=%0d got=%h req=%h", i, log_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (byp != 4) begin
            bad++; $display("FAIL bypass_cycles got=%0d req=4", byp);
        end
    endtask

    task automatic test_random_iters();
        logic [DATA_W-1:0] d;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                total++;
                if (obs() !== 21'h0) begin
                    bad++; $display("FAIL idle it=%0d got=%h req=0", it, obs());
                end
            end
            d = DATA_W'($urandom); sv = 1'b1; sd = d;
            for (int off = 1; off <= LAST; off++) begin
                @(negedge clk); sv = 1'b0; sd = DATA_W'($urandom);
                total++;
                if (obs() !== exp_vec(off) || SampleReg !== d) begin
                    bad++; $display("FAIL random it=%0d off=%0d got=%h req=%h smp=%h/%h", it, off, obs(), exp_vec(off), SampleReg, d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d[2];
        d[0] = DATA_W'($urandom); d[1] = DATA_W'($urandom);
        do_reset();
        sv = 1'b1; sd = d[0];
        for (int n = 0; n < 2; n++) begin
            for (int off = 1; off <= LAST; off++) begin
                @(negedge clk); sv = 1'b0;
                total++;
                if (obs() !== exp_vec(off) || SampleReg !== d[n]) begin
                    bad++; $display("FAIL b2b n=%0d off=%0d got=%h req=%h smp=%h/%h", n, off, obs(), exp_vec(off), SampleReg, d[n]);
                end
                if (off == LAST && n == 0) begin sv = 1'b1; sd = d[1]; end
            end
        end
        @(negedge clk);
        total++;
        if (obs() !== 21'h0) begin
            bad++; $display("FAIL b2b_idle got=%h req=0", obs());
        end
    endtask

    // off2 < 0 means no second busy-time arrival
    task automatic test_overrun(input int off1, input int off2);
        logic [DATA_W-1:0] a, b, c, es;
        logic [20:0] e;
        a = DATA_W'($urandom); b = DATA_W'($urandom); c = DATA_W'($urandom);
        do_reset();
        sv = 1'b1; sd = a;
        for (int off = 1; off <= LAST + 1; off++) begin
            @(negedge clk); sv = 1'b0;
            e  = exp_vec(off);
            es = a;
`ifdef ANC_SEQ_PENDING_EN
            if (off == off2 + 1) e[0] = 1'b1;
            if (off == LAST + 1) begin
                e  = exp_vec(1);
                es = (off2 > 0) ? c : b;
            end
`else
            if (off == off1 + 1 || off == off2 + 1) e[0] = 1'b1;
`endif
            total++;
            if (obs() !== e || SampleReg !== es) begin
                bad++; $display("FAIL overrun off1=%0d off=%0d got=%h req=%h smp=%h/%h", off1, off, obs(), e, SampleReg, es);
            end
            if (off == off1) begin sv = 1'b1; sd = b; end
            if (off == off2) begin sv = 1'b1; sd = c; end
        end
    endtask

    task automatic test_mid_reset();
        logic [DATA_W-1:0] d;
        do_reset();
        sv = 1'b1; sd = DATA_W'($urandom);
        for (int off = 1; off <= 51; off++) begin
            @(negedge clk); sv = 1'b0;
            total++;
            if (off <= 50) begin
                if (obs() !== exp_vec(off)) begin
                    bad++; $display("FAIL pre_reset off=%0d got=%h req=%h", off, obs(), exp_vec(off));
                end
            end else if (obs() !== 21'h0 || SampleReg !== '0) begin
                bad++; $display("FAIL mid_reset got=%h req=0 smp=%h", obs(), SampleReg);
            end
            // reset and a new sample land on the same edge
            if (off == 50) begin rst = 1'b1; sv = 1'b1; sd = DATA_W'($urandom); end
        end
        rst = 1'b0;
        d = DATA_W'($urandom); sv = 1'b1; sd = d;
        for (int off = 1; off <= 10; off++) begin
            @(negedge clk); sv = 1'b0;
            total++;
            if (obs() !== exp_vec(off) || SampleReg !== d) begin
                bad++; $display("FAIL restart off=%0d got=%h req=%h smp=%h/%h", off, obs(), exp_vec(off), SampleReg, d);
            end
        end
    endtask

    initial begin
        int o1, o2;
        rst = 1'b1; sv = 1'b0; sd = '0;
        test_reset();
        test_single();
        test_random_iters();
        test_back_to_back();
        test_overrun(100, -5);
        o1 = int'($urandom_range(1, 150));
        o2 = int'($urandom_range(o1 + 1, SWR_OFF));
        test_overrun(o1, o2);
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
